// File: rtl/rs_latch_nand_driver_pkg.sv
// Shared encodings and sizing helpers for the NAND RS-latch driver.
// Pure declarations: no logic, no latency, no flow control.
package rs_latch_nand_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

  // Counter must hold max(PULSE_W, GAP_W)-1; never narrower than one bit.
  function automatic int cnt_width(input int pulse_w, input int gap_w);
    int m;
    int w;
    m = (pulse_w > gap_w) ? pulse_w : gap_w;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rs_latch_nand_driver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
// Latency 2 clk edges; no flow control.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;

  always_comb begin
    ff1_d = d;
    ff2_d = ff1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/rs_latch_nand_driver.sv
// Drives s_n/r_n of a NAND RS latch with timed exclusive pulses, then reads q back.
// One command per PULSE_W+GAP_W+1 cycles; cmd_ready low while a command is in flight.
module rs_latch_nand_driver
  import rs_latch_nand_driver_pkg::*;
#(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_op,
  output logic cmd_ready,
  output logic s_n,
  output logic r_n,
  input  logic q_fb,
  output logic q_now,
  output logic done,
  output logic err
);

  localparam int CW = cnt_width(PULSE_W, GAP_W);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_W - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          target_q, target_d;
  logic          s_n_q, s_n_d;
  logic          r_n_q, r_n_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          finish;

  sync_2ff u_sync_q (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_fb),
    .q     (q_now)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      target_q <= OP_RST;
      s_n_q    <= 1'b1;
      r_n_q    <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      s_n_q    <= s_n_d;
      r_n_q    <= r_n_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    finish   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          target_d = cmd_op;
          cnt_d    = PULSE_LOAD;
          state_d  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulse levels come from the next state so they are registered with it;
  // a single pulse condition gates both lines, so they can never both be low.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    s_n_d     = !((state_d == ST_PULSE) && (target_d == OP_SET));
    r_n_d     = !((state_d == ST_PULSE) && (target_d == OP_RST));
    done_d    = finish;
    err_d     = finish && (q_now != target_q);
  end

  assign s_n  = s_n_q;
  assign r_n  = r_n_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_rs_latch_nand_driver.sv
// Bench: driver instances (default timing and PULSE_W=1/GAP_W=2) each wired to a NAND latch model.
module tb_rs_latch_nand_driver;

  localparam int P0 = 4;
  localparam int G0 = 2;
  localparam int P1 = 1;
  localparam int G1 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic cmd_valid0 = 1'b0, cmd_op0 = 1'b0, cmd_ready0, s_n0, r_n0, q_fb0, q_now0, done0, err0;
  logic cmd_valid1 = 1'b0, cmd_op1 = 1'b0, cmd_ready1, s_n1, r_n1, q_fb1, q_now1, done1, err1;

  logic q_lat0 = 1'b0;
  logic q_lat1 = 1'b0;
  logic frc0 = 1'b0, fval0 = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  bit excl_on = 1'b0;

  always #5 clk = ~clk;

  // NAND latch: a low s_n forces q=1, a low r_n forces q=0, otherwise hold.
  always @(s_n0 or r_n0) begin
    if (s_n0 === 1'b0) q_lat0 = 1'b1;
    else if (r_n0 === 1'b0) q_lat0 = 1'b0;
  end
  always @(s_n1 or r_n1) begin
    if (s_n1 === 1'b0) q_lat1 = 1'b1;
    else if (r_n1 === 1'b0) q_lat1 = 1'b0;
  end

  assign q_fb0 = frc0 ? fval0 : q_lat0;
  assign q_fb1 = q_lat1;

  rs_latch_nand_driver #(.PULSE_W(P0), .GAP_W(G0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid0), .cmd_op(cmd_op0),
    .cmd_ready(cmd_ready0), .s_n(s_n0), .r_n(r_n0), .q_fb(q_fb0),
    .q_now(q_now0), .done(done0), .err(err0)
  );

  rs_latch_nand_driver #(.PULSE_W(P1), .GAP_W(G1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_op(cmd_op1),
    .cmd_ready(cmd_ready1), .s_n(s_n1), .r_n(r_n1), .q_fb(q_fb1),
    .q_now(q_now1), .done(done1), .err(err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (excl_on) begin
      check("excl0", {31'd0, (s_n0 | r_n0)}, 32'd1);
      check("excl1", {31'd0, (s_n1 | r_n1)}, 32'd1);
    end
  end

  typedef struct {
    bit op;
    bit frc;
    bit fval;
    bit exp_q;
    bit exp_err;
  } vec_t;

  task automatic run_cmd(input string tag, input bit op, input bit frc, input bit fval,
                         input bit exp_q, input bit exp_err);
    int s_lo = 0, r_lo = 0, rdy_lo = 0, d_cnt = 0, d_at = 0, e_cnt = 0, e_at = 0;
    @(negedge clk);
    frc0 = frc;
    fval0 = fval;
    check({tag, "_ready_pre"}, {31'd0, cmd_ready0}, 32'd1);
    cmd_valid0 = 1'b1;
    cmd_op0 = op;
    @(posedge clk);
    #1;
    cmd_valid0 = 1'b0;
    cmd_op0 = ~op;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (!s_n0) s_lo++;
      if (!r_n0) r_lo++;
      if (!cmd_ready0) rdy_lo++;
      if (done0) begin d_cnt++; d_at = j; end
      if (err0) begin e_cnt++; e_at = j; end
    end
    check({tag, "_s_lo"}, s_lo, op ? P0 : 0);
    check({tag, "_r_lo"}, r_lo, op ? 0 : P0);
    check({tag, "_busy"}, rdy_lo, P0 + G0);
    check({tag, "_done_cnt"}, d_cnt, 1);
    check({tag, "_done_at"}, d_at, P0 + G0 + 1);
    check({tag, "_err_cnt"}, e_cnt, exp_err ? 1 : 0);
    check({tag, "_err_at"}, e_at, exp_err ? P0 + G0 + 1 : 0);
    check({tag, "_q_now"}, {31'd0, q_now0}, {31'd0, exp_q});
    if (!frc) check({tag, "_latch"}, {31'd0, q_lat0}, {31'd0, op});
    frc0 = 1'b0;
  endtask

  vec_t vecs[6];
  int k, acc, accepted, done1_cnt, first_rdy, d_cnt, e_cnt, r_lo;
  bit acc_op, exp_ready, pulse, take;

  initial begin
    vecs[0] = '{op: 1'b1, frc: 1'b0, fval: 1'b0, exp_q: 1'b1, exp_err: 1'b0};
    vecs[1] = '{op: 1'b1, frc: 1'b0, fval: 1'b0, exp_q: 1'b1, exp_err: 1'b0};
    vecs[2] = '{op: 1'b0, frc: 1'b0, fval: 1'b0, exp_q: 1'b0, exp_err: 1'b0};
    vecs[3] = '{op: 1'b1, frc: 1'b1, fval: 1'b0, exp_q: 1'b0, exp_err: 1'b1};
    vecs[4] = '{op: 1'b0, frc: 1'b1, fval: 1'b1, exp_q: 1'b1, exp_err: 1'b1};
    vecs[5] = '{op: 1'b0, frc: 1'b0, fval: 1'b0, exp_q: 1'b0, exp_err: 1'b0};

    excl_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_n", {31'd0, s_n0}, 32'd1);
    check("rst_r_n", {31'd0, r_n0}, 32'd1);
    check("rst_ready", {31'd0, cmd_ready0}, 32'd1);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_err", {31'd0, err0}, 32'd0);
    check("rst_q_now", {31'd0, q_now0}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].frc, vecs[i].fval,
              vecs[i].exp_q, vecs[i].exp_err);

    // Back-to-back set then reset with cmd_valid held high.
    @(negedge clk);
    cmd_valid0 = 1'b1;
    cmd_op0 = 1'b1;
    @(posedge clk);
    #1;
    cmd_op0 = 1'b0;
    first_rdy = 0; d_cnt = 0; e_cnt = 0; r_lo = 0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (done0) d_cnt++;
      if (err0) e_cnt++;
      if (!r_n0) r_lo++;
      if (cmd_ready0 && first_rdy == 0) first_rdy = j;
      if (j == 8) cmd_valid0 = 1'b0;
    end
    check("b2b_accept_gap", first_rdy, P0 + G0 + 1);
    check("b2b_r_lo", r_lo, P0);
    check("b2b_done_cnt", d_cnt, 2);
    check("b2b_err_cnt", e_cnt, 0);
    check("b2b_q_now", {31'd0, q_now0}, 32'd0);

    // Abort mid-pulse: reset must release s_n without waiting for a clock.
    @(negedge clk);
    cmd_valid0 = 1'b1;
    cmd_op0 = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_s_n_pre", {31'd0, s_n0}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_s_n", {31'd0, s_n0}, 32'd1);
    check("abort_r_n", {31'd0, r_n0}, 32'd1);
    check("abort_ready", {31'd0, cmd_ready0}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (done0) d_cnt++;
    end
    check("abort_no_done", d_cnt, 0);
    run_cmd("post_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random commands on the short-timing instance against an edge-count model.
    k = 0; acc = -100; acc_op = 1'b0; accepted = 0; done1_cnt = 0;
    for (int cyc = 0; cyc < 4000 && accepted < 200; cyc++) begin
      @(negedge clk);
      exp_ready = (k >= acc + P1 + G1);
      pulse = (k >= acc) && (k <= acc + P1 - 1);
      check("rnd_ready", {31'd0, cmd_ready1}, {31'd0, exp_ready});
      check("rnd_s_n", {31'd0, s_n1}, {31'd0, !(pulse && acc_op)});
      check("rnd_r_n", {31'd0, r_n1}, {31'd0, !(pulse && !acc_op)});
      check("rnd_done", {31'd0, done1}, {31'd0, (k == acc + P1 + G1)});
      check("rnd_err", {31'd0, err1}, 32'd0);
      if (done1) done1_cnt++;
      cmd_valid1 = ($urandom_range(0, 3) != 0);
      cmd_op1 = 1'($urandom_range(0, 1));
      take = cmd_valid1 && exp_ready;
      @(posedge clk);
      k++;
      if (take) begin
        acc = k;
        acc_op = cmd_op1;
        accepted++;
      end
    end
    #1;
    cmd_valid1 = 1'b0;
    check("rnd_accepted", accepted, 200);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (done1) done1_cnt++;
    end
    check("rnd_done_total", done1_cnt, accepted);
    check("rnd_q_now", {31'd0, q_now1}, {31'd0, acc_op});

    excl_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
